sqrt_iter_unit: RTL
===================

Name: sqrt_iter_unit

Overview:
- Parametrised iterative integer square-root unit: the next generation of the odd-number-summation sqrt engine.
- Computes root = floor(sqrt(x)) and remainder = x - root^2 for an unsigned WIDTH-bit operand.
- Uses one compare/accumulate step per clock and valid/ready handshakes on both input and output.
- Controller FSM and datapath live in one block; it sits between an operand producer and a result consumer.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 2. Elaboration error otherwise.
- RW, WIDTH/2, root width (derived; not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous abort; forces IDLE and discards any operation in progress.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  unit can accept an operand.
- x_i  in  WIDTH  unsigned operand.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- root_o  out  RW  floor(sqrt(x)).
- rem_o  out  RW+1  x - root^2; range 0..2*root.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst_i high, async): state=IDLE. in_ready_o=1 once reset is released. out_valid_o=0, root_o=0, rem_o=0, busy_o=0. All internal registers are cleared.
- Internal registers:
  - X: WIDTH bits, latched operand.
  - S: WIDTH+1 bits, invariant S=(R+1)^2.
  - D: RW+2 bits, invariant D=2R+1.
  - R: RW bits.
  - S must be WIDTH+1 bits because S reaches 2^WIDTH when x = 2^WIDTH-1. No register may wrap.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: X<=x_i, S<=1, D<=1, R<=0, go to ITER.
- ITER:
  - in_ready_o=0.
  - If S > X: go to DONE. root_o<=R, rem_o<=X-(S-D), computed at full width and truncated to RW+1.
  - Else: R<=R+1, D<=D+2, S<=S+D+2. Stay in ITER.
- DONE:
  - out_valid_o=1. root_o and rem_o are held stable.
  - On out_ready_i: go to IDLE with out_valid_o=0 on the next cycle.
  - in_ready_o=0 in DONE. A new operand is accepted only from IDLE, so back-to-back throughput is one result per root+3 cycles.
- Latency: out_valid_o rises root+1 cycles after the accepting edge. For x=0 it is high the cycle after ITER's first evaluation.
- root_o and rem_o are updated only on ITER->DONE. They keep their last values through IDLE and ITER.
- in_valid_i while busy is ignored. The operand is not captured, and the producer must hold it.
- out_ready_i outside DONE has no effect.
- clear_i has priority over all transitions except rst_i:
  - Next state is IDLE and out_valid_o=0 next cycle.
  - root_o and rem_o are unchanged.
  - An in_valid_i in the same cycle as clear_i is not accepted.
- Asserting rst_i mid-operation returns to the reset values immediately (async). No result is produced.
- Illegal state encoding: next state is IDLE.

Test Plan:
- WIDTH=16, x=0 -> out_valid_o 1 cycle after accept, root_o=0, rem_o=0.
- x=1 -> root 1, rem 0, latency 2. x=15 -> root 3, rem 6, latency 4. x=16 -> root 4, rem 0, latency 5.
- x=65535 -> root 255, rem 510, latency 256; no overflow of S (S=65536 at exit).
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o and outputs stay stable, in_ready_o=0, and a pulsed in_valid_i is ignored. Release -> IDLE, next operand accepted.
- clear_i asserted 3 cycles into x=10000 -> IDLE next cycle, no out_valid_o. A following x=99 gives root 9, rem 18.
- rst_i pulsed mid-ITER -> outputs 0 asynchronously, busy_o=0. Random sweep of 1000 operands matches the reference model.

Source files
------------

// File: rtl/sqrt_iter_unit_if.sv
// Operand/result handshake bundle for sqrt_iter_unit.
// The master side is the producer/consumer, the slave side is the unit.
interface sqrt_iter_unit_if #(
  parameter int WIDTH = 16
);
  localparam int RW = WIDTH / 2;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] x_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [RW-1:0]    root_o;
  logic [RW:0]      rem_o;

  modport master (
    output in_valid_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, root_o, rem_o
  );

  modport slave (
    input  in_valid_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, root_o, rem_o
  );
endinterface

// File: rtl/sqrt_iter_unit.sv
// Iterative floor(sqrt(x)) engine summing odd numbers: one compare/accumulate
// step per clock, valid/ready handshake on operand and result.
module sqrt_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  output logic            busy_o,
  sqrt_iter_unit_if.slave bus
);
  localparam int RW = WIDTH / 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
    $error("sqrt_iter_unit: WIDTH must be even and >= 2");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH:0]   s_q, s_d;
  logic [RW+1:0]    d_q, d_d;
  logic [RW-1:0]    r_q, r_d;
  logic [RW-1:0]    root_q, root_d;
  logic [RW:0]      rem_q, rem_d;
  logic [WIDTH:0]   r_sq;

  // S = (R+1)^2 and D = 2R+1, so S - D recovers R^2 without a multiplier
  assign r_sq = s_q - (WIDTH+1)'(d_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    s_d     = s_q;
    d_d     = d_q;
    r_d     = r_q;
    root_d  = root_q;
    rem_d   = rem_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            x_d     = bus.x_i;
            s_d     = (WIDTH+1)'(1);
            d_d     = (RW+2)'(1);
            r_d     = '0;
            state_d = ST_ITER;
          end
        end
        ST_ITER: begin
          if (s_q > {1'b0, x_q}) begin
            root_d  = r_q;
            rem_d   = (RW+1)'({1'b0, x_q} - r_sq);
            state_d = ST_DONE;
          end else begin
            r_d = r_q + RW'(1);
            d_d = d_q + (RW+2)'(2);
            s_d = s_q + (WIDTH+1)'(d_q) + (WIDTH+1)'(2);
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      s_q     <= s_d;
      d_q     <= d_d;
      r_q     <= r_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.in_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign bus.out_valid_o = (state_q == ST_DONE);
  assign bus.root_o      = root_q;
  assign bus.rem_o       = rem_q;
  assign busy_o          = (state_q != ST_IDLE);
endmodule
